// File: rtl/hazard_sb_if.sv
// Signal bundle between the pipeline datapath and the hazard/scoreboard controller.
// Long-op contract: an op issues on the clock where longE=1 and stallE=0; long_done marks its writeback.
interface hazard_sb_if #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int NSRC  = 2,
    parameter int CNT_W = 32
);
    logic                i_wait;
    logic                d_wait;
    logic                dbranch;
    logic [NSRC*AW-1:0]  ra_d;
    logic                wr_d;
    logic [AW-1:0]       dst_d;
    logic                long_d;
    logic [NSRC*AW-1:0]  ra_e;
    logic [AW-1:0]       edst;
    logic [AW-1:0]       mdst;
    logic [AW-1:0]       wdst;
    logic                wrE;
    logic                wrM;
    logic                wrW;
    logic                memrdE;
    logic                memrdM;
    logic                longE;
    logic                long_done;
    logic [AW-1:0]       long_dst;

    logic                stallF;
    logic                stallD;
    logic                stallE;
    logic                stallM;
    logic                flushD;
    logic                flushE;
    logic                flushW;
    logic [NSRC-1:0]     fwd_d;
    logic [NSRC*2-1:0]   fwd_e;
    logic                sb_busy;
    logic [CNT_W-1:0]    stall_cycles;
    logic [NREG-1:0]     dbgPending;
    logic [2:0]          dbgLongCnt;

    modport master (
        output i_wait, d_wait, dbranch, ra_d, wr_d, dst_d, long_d, ra_e,
               edst, mdst, wdst, wrE, wrM, wrW, memrdE, memrdM, longE,
               long_done, long_dst,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               fwd_d, fwd_e, sb_busy, stall_cycles, dbgPending, dbgLongCnt
    );

    modport slave (
        input  i_wait, d_wait, dbranch, ra_d, wr_d, dst_d, long_d, ra_e,
               edst, mdst, wdst, wrE, wrM, wrW, memrdE, memrdM, longE,
               long_done, long_dst,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               fwd_d, fwd_e, sb_busy, stall_cycles, dbgPending, dbgLongCnt
    );
endinterface

// File: rtl/hazard_sb.sv
// Hazard controller for the 5-stage core with a register scoreboard tracking
// out-of-order writeback of long-latency (mul/div) ops.
module hazard_sb #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NSRC     = 2,
    parameter int MAX_LONG = 2,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    hazard_sb_if.slave  hz
);
    localparam int LCW = 3;

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_IWAIT,
        MODE_DWAIT,
        MODE_RESET
    } mode_t;

    mode_t             mode;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pendingNext;
    logic [LCW-1:0]    longCnt;
    logic [CNT_W-1:0]  stallCycles;

    logic matchE, matchM, srcPend;
    logic lwStall, brStall, sbStall, capStall, hazStall, issue;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [NSRC-1:0]   fwdD;
    logic [NSRC*2-1:0] fwdE;

    always_comb begin : mode_sel
        if (reset)          mode = MODE_RESET;
        else if (hz.d_wait) mode = MODE_DWAIT;
        else if (hz.i_wait) mode = MODE_IWAIT;
        else                mode = MODE_NORMAL;
    end

    always_comb begin : hazard_detect
        logic [AW-1:0] src;
        src     = '0;
        matchE  = 1'b0;
        matchM  = 1'b0;
        srcPend = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src = hz.ra_d[i*AW +: AW];
            if (src != '0) begin
                if (src == hz.edst)  matchE  = 1'b1;
                if (src == hz.mdst)  matchM  = 1'b1;
                if (pending[src])    srcPend = 1'b1;
            end
        end
        lwStall  = hz.memrdE & hz.wrE & matchE;
        brStall  = hz.dbranch & ((hz.wrE & matchE) | (hz.memrdM & matchM));
        // pending[0] is never set, so dst_d == x0 cannot raise a WAW stall.
        sbStall  = srcPend | (hz.wr_d & pending[hz.dst_d]);
        capStall = hz.long_d & (longCnt == LCW'(MAX_LONG)) & ~hz.long_done;
        hazStall = lwStall | brStall | sbStall | capStall;
    end

    always_comb begin : ctrl_out
        logic [AW-1:0] r;
        r      = '0;
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        fwdD   = '0;
        fwdE   = '0;
        unique case (mode)
            MODE_RESET: ;
            MODE_DWAIT: begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end
            MODE_IWAIT: begin
                stallF = 1'b1;
                if (hz.dbranch) begin
                    stallD = 1'b1;
                    flushE = 1'b1;
                end else begin
                    flushD = 1'b1;
                end
            end
            MODE_NORMAL: begin
                stallD = hazStall;
                stallF = hazStall;
                flushE = hazStall;
                flushD = hz.dbranch & ~hazStall;
                // The long unit result outranks M/W: it is the newest write to that register.
                for (int i = 0; i < NSRC; i++) begin
                    r = hz.ra_e[i*AW +: AW];
                    if (r != '0) begin
                        if (hz.long_done && hz.long_dst == r) fwdE[i*2 +: 2] = 2'b11;
                        else if (hz.wrM && hz.mdst == r)      fwdE[i*2 +: 2] = 2'b10;
                        else if (hz.wrW && hz.wdst == r)      fwdE[i*2 +: 2] = 2'b01;
                    end
                    r = hz.ra_d[i*AW +: AW];
                    fwdD[i] = (r != '0) && hz.wrM && (hz.mdst == r);
                end
            end
        endcase
    end

    assign issue = hz.longE & ~hz.d_wait & ~stallE;

    always_comb begin : sb_next
        pendingNext = pending;
        if (hz.long_done) pendingNext[hz.long_dst] = 1'b0;
        if (issue && hz.wrE && hz.edst != '0) pendingNext[hz.edst] = 1'b1;
        pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            longCnt     <= '0;
            stallCycles <= '0;
        end else begin
            pending <= pendingNext;
            if (issue && !hz.long_done)
                longCnt <= longCnt + 1'b1;
            else if (!issue && hz.long_done && longCnt != '0)
                longCnt <= longCnt - 1'b1;
            if (stallD) stallCycles <= stallCycles + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(hz.long_done && longCnt == '0));
    end

    assign hz.stallF       = stallF;
    assign hz.stallD       = stallD;
    assign hz.stallE       = stallE;
    assign hz.stallM       = stallM;
    assign hz.flushD       = flushD;
    assign hz.flushE       = flushE;
    assign hz.flushW       = flushW;
    assign hz.fwd_d        = fwdD;
    assign hz.fwd_e        = fwdE;
    assign hz.sb_busy      = |pending;
    assign hz.stall_cycles = stallCycles;
    assign hz.dbgPending   = pending;
    assign hz.dbgLongCnt   = longCnt;
endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: directed scenarios plus randomized traffic against a
// behavioural model (pending bit array, queue of in-flight long ops, stall counter).
module tb_hazard_sb;
    localparam int NREG     = 32;
    localparam int AW       = 5;
    localparam int NSRC     = 2;
    localparam int MAX_LONG = 2;
    localparam int CNT_W    = 32;

    typedef struct packed {
        logic              stallF;
        logic              stallD;
        logic              stallE;
        logic              stallM;
        logic              flushD;
        logic              flushE;
        logic              flushW;
        logic [NSRC-1:0]   fwdD;
        logic [NSRC*2-1:0] fwdE;
        logic              sbBusy;
        logic [2:0]        longCnt;
        logic [NREG-1:0]   pending;
        logic [CNT_W-1:0]  stallCycles;
    } outs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_sb_if #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .CNT_W(CNT_W)) hz();

    hazard_sb #(
        .NREG(NREG), .AW(AW), .NSRC(NSRC), .MAX_LONG(MAX_LONG), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
    );

    bit               mPend[NREG];
    logic [AW-1:0]    mInflight[$];
    logic [CNT_W-1:0] mStalls;
    int               checks = 0;
    int               errors = 0;
    outs_t            act, exp;

    function automatic bit dReads(input logic [AW-1:0] r);
        if (r == '0) return 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (hz.ra_d[i*AW +: AW] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit dReadsPending();
        for (int i = 0; i < NSRC; i++)
            if (mPend[hz.ra_d[i*AW +: AW]]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic outs_t modelOut();
        outs_t o;
        bit hold;
        logic [AW-1:0] r;
        o = '0;
        for (int k = 0; k < NREG; k++) o.pending[k] = mPend[k];
        o.sbBusy      = (o.pending != '0);
        o.longCnt     = 3'(mInflight.size());
        o.stallCycles = mStalls;
        if (reset) return o;
        if (hz.d_wait) begin
            {o.stallF, o.stallD, o.stallE, o.stallM, o.flushW} = 5'b11111;
        end else if (hz.i_wait) begin
            o.stallF = 1'b1;
            o.stallD = hz.dbranch;
            o.flushE = hz.dbranch;
            o.flushD = !hz.dbranch;
        end else begin
            hold = (hz.memrdE && hz.wrE && dReads(hz.edst))
                || (hz.dbranch && ((hz.wrE && dReads(hz.edst)) || (hz.memrdM && dReads(hz.mdst))))
                || dReadsPending() || (hz.wr_d && mPend[hz.dst_d])
                || (hz.long_d && mInflight.size() == MAX_LONG && !hz.long_done);
            o.stallD = hold;
            o.stallF = hold;
            o.flushE = hold;
            o.flushD = hz.dbranch && !hold;
            for (int i = 0; i < NSRC; i++) begin
                r = hz.ra_e[i*AW +: AW];
                if (r != 0) begin
                    if (hz.long_done && hz.long_dst == r) o.fwdE[i*2 +: 2] = 2'b11;
                    else if (hz.wrM && hz.mdst == r)      o.fwdE[i*2 +: 2] = 2'b10;
                    else if (hz.wrW && hz.wdst == r)      o.fwdE[i*2 +: 2] = 2'b01;
                end
                r = hz.ra_d[i*AW +: AW];
                o.fwdD[i] = (r != 0) && hz.wrM && hz.mdst == r;
            end
        end
        return o;
    endfunction

    function automatic void modelStep();
        outs_t e;
        bit issue;
        if (reset) begin
            for (int k = 0; k < NREG; k++) mPend[k] = 1'b0;
            mInflight.delete();
            mStalls = '0;
            return;
        end
        e = modelOut();
        issue = hz.longE && !hz.d_wait && !e.stallE;
        if (hz.long_done) begin
            mPend[hz.long_dst] = 1'b0;
            for (int k = 0; k < mInflight.size(); k++)
                if (mInflight[k] == hz.long_dst) begin
                    mInflight.delete(k);
                    break;
                end
        end
        if (issue && hz.wrE && hz.edst != 0) mPend[hz.edst] = 1'b1;
        if (issue) mInflight.push_back(hz.edst);
        if (e.stallD) mStalls = mStalls + 1'b1;
    endfunction

    function automatic outs_t sampleDut();
        outs_t s;
        s.stallF      = hz.stallF;
        s.stallD      = hz.stallD;
        s.stallE      = hz.stallE;
        s.stallM      = hz.stallM;
        s.flushD      = hz.flushD;
        s.flushE      = hz.flushE;
        s.flushW      = hz.flushW;
        s.fwdD        = hz.fwd_d;
        s.fwdE        = hz.fwd_e;
        s.sbBusy      = hz.sb_busy;
        s.longCnt     = hz.dbgLongCnt;
        s.pending     = hz.dbgPending;
        s.stallCycles = hz.stall_cycles;
        return s;
    endfunction

    task automatic clearInputs();
        hz.i_wait = 0; hz.d_wait = 0; hz.dbranch = 0;
        hz.ra_d = '0; hz.wr_d = 0; hz.dst_d = '0; hz.long_d = 0;
        hz.ra_e = '0; hz.edst = '0; hz.mdst = '0; hz.wdst = '0;
        hz.wrE = 0; hz.wrM = 0; hz.wrW = 0; hz.memrdE = 0; hz.memrdM = 0;
        hz.longE = 0; hz.long_done = 0; hz.long_dst = '0;
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        clearInputs();
        hz.d_wait = 1; hz.i_wait = 1; hz.dbranch = 1;
        hz.wrM = 1; hz.mdst = 5'd3; hz.ra_e = {5'd3, 5'd3}; hz.ra_d = {5'd3, 5'd3};
        tick();
        tick();
        act = sampleDut(); exp = modelOut(); checks++;
        if (act !== exp) begin
            errors++; $display("FAIL reset_model: got %h required %h", act, exp);
        end
        checks++;
        if ({act.stallF, act.stallD, act.stallE, act.stallM, act.flushD, act.flushE,
             act.flushW, act.fwdD, act.fwdE} !== '0) begin
            errors++; $display("FAIL reset_ctrl_zero: got %h required 0", act);
        end
        checks++;
        if ({act.pending, act.longCnt, act.stallCycles, act.sbBusy} !== '0) begin
            errors++; $display("FAIL reset_state_zero: got %h required 0", act);
        end
        reset = 0;
        clearInputs();
    endtask

    task automatic test_load_use();
        hz.edst = 5'd5; hz.wrE = 1; hz.memrdE = 1; hz.ra_d = {5'd0, 5'd5};
        #1;
        act = sampleDut(); exp = modelOut(); checks++;
        if (act !== exp) begin
            errors++; $display("FAIL load_use_model: got %h required %h", act, exp);
        end
        checks++;
        if ({act.stallD, act.stallF, act.flushE, act.stallE} !== 4'b1110) begin
            errors++; $display("FAIL load_use_stall: got %b required 1110",
                               {act.stallD, act.stallF, act.flushE, act.stallE});
        end
        tick();
        hz.mdst = 5'd5; hz.wrM = 1; hz.memrdM = 1;
        hz.ra_e = {5'd0, 5'd5}; hz.edst = 5'd6; hz.memrdE = 0; hz.ra_d = '0;
        #1;
        act = sampleDut(); exp = modelOut(); checks++;
        if (act !== exp) begin
            errors++; $display("FAIL load_fwd_model: got %h required %h", act, exp);
        end
        checks++;
        if (act.fwdE !== 4'b0010 || act.stallD !== 1'b0) begin
            errors++; $display("FAIL load_fwd_m: got fwd_e=%b stallD=%b required 0010/0",
                               act.fwdE, act.stallD);
        end
        tick();
        clearInputs();
    endtask

    task automatic test_long_dep();
        logic [CNT_W-1:0] startStalls;
        hz.longE = 1; hz.wrE = 1; hz.edst = 5'd7;
        tick();
        clearInputs();
        startStalls = mStalls;
        hz.ra_d = {5'd0, 5'd7};
        for (int c = 0; c < 6; c++) begin
            hz.long_done = (c == 4); hz.long_dst = 5'd7;
            #1;
            act = sampleDut(); exp = modelOut(); checks++;
            if (act !== exp) begin
                errors++; $display("FAIL long_dep_model c%0d: got %h required %h", c, act, exp);
            end
            checks++;
            if (act.stallD !== (c < 5) || act.sbBusy !== (c < 5)) begin
                errors++; $display("FAIL long_dep_stall c%0d: got stallD=%b busy=%b required %b",
                                   c, act.stallD, act.sbBusy, c < 5);
            end
            tick();
        end
        checks++;
        if (act.stallCycles !== startStalls + 5) begin
            errors++; $display("FAIL long_dep_count: got %0d required %0d",
                               act.stallCycles, startStalls + 5);
        end
        clearInputs();
    endtask

    task automatic test_cap();
        hz.longE = 1; hz.wrE = 1; hz.edst = 5'd10;
        tick();
        hz.edst = 5'd11;
        tick();
        clearInputs();
        hz.long_d = 1; hz.wr_d = 1; hz.dst_d = 5'd12;
        for (int c = 0; c < 2; c++) begin
            hz.long_done = (c == 1); hz.long_dst = 5'd10;
            #1;
            act = sampleDut(); exp = modelOut(); checks++;
            if (act !== exp) begin
                errors++; $display("FAIL cap_model c%0d: got %h required %h", c, act, exp);
            end
            checks++;
            if (act.stallD !== (c == 0) || act.longCnt !== 3'd2) begin
                errors++; $display("FAIL cap_stall c%0d: got stallD=%b cnt=%0d required %b/2",
                                   c, act.stallD, act.longCnt, c == 0);
            end
            if (c == 0) tick();
        end
        tick();
        clearInputs();
        hz.long_done = 1; hz.long_dst = 5'd11;
        tick();
        clearInputs();
    endtask

    task automatic test_dwait_issue();
        hz.d_wait = 1; hz.i_wait = 1; hz.longE = 1; hz.wrE = 1; hz.edst = 5'd13;
        #1;
        act = sampleDut(); checks++;
        if ({act.stallF, act.stallD, act.stallE, act.stallM, act.flushW, act.flushD, act.flushE} !== 7'b1111100) begin
            errors++; $display("FAIL dwait_ctrl: got %b required 1111100",
                {act.stallF, act.stallD, act.stallE, act.stallM, act.flushW, act.flushD, act.flushE});
        end
        tick();
        act = sampleDut(); checks++;
        if (act.pending[13] !== 1'b0 || act.longCnt !== 3'd0) begin
            errors++; $display("FAIL dwait_hold: got pend=%b cnt=%0d required 0/0", act.pending[13], act.longCnt);
        end
        hz.d_wait = 0; hz.i_wait = 0;
        tick();
        act = sampleDut(); exp = modelOut(); checks++;
        if (act.pending[13] !== 1'b1 || act.longCnt !== 3'd1 || act !== exp) begin
            errors++; $display("FAIL dwait_release: got %h required %h", act, exp);
        end
        clearInputs();
        hz.long_done = 1; hz.long_dst = 5'd13;
        tick();
        clearInputs();
    endtask

    task automatic test_fwd_long();
        hz.longE = 1; hz.wrE = 1; hz.edst = 5'd9;
        tick();
        clearInputs();
        hz.long_done = 1; hz.long_dst = 5'd9; hz.ra_e = {5'd0, 5'd9};
        hz.wrM = 1; hz.mdst = 5'd9; hz.wrW = 1; hz.wdst = 5'd0;
        #1;
        act = sampleDut(); checks++;
        if (act.fwdE !== 4'b0011) begin
            errors++; $display("FAIL fwd_long: got %b required 0011", act.fwdE);
        end
        tick();
        clearInputs();
        hz.ra_e = {5'd4, 5'd4}; hz.wrM = 1; hz.mdst = 5'd4; hz.wrW = 1; hz.wdst = 5'd4;
        hz.ra_d = {5'd4, 5'd0};
        #1;
        act = sampleDut(); exp = modelOut(); checks++;
        if (act.fwdE !== 4'b1010 || act.fwdD !== 2'b10 || act !== exp) begin
            errors++; $display("FAIL fwd_m_prio: got %h required %h", act, exp);
        end
        tick();
        clearInputs();
    endtask

    task automatic test_branch_iwait();
        hz.i_wait = 1; hz.dbranch = 1;
        #1;
        act = sampleDut(); checks++;
        if ({act.stallF, act.stallD, act.flushD, act.flushE} !== 4'b1101) begin
            errors++; $display("FAIL iwait_branch: got %b required 1101",
                               {act.stallF, act.stallD, act.flushD, act.flushE});
        end
        hz.dbranch = 0;
        #1;
        act = sampleDut(); checks++;
        if ({act.stallF, act.stallD, act.flushD, act.flushE} !== 4'b1010) begin
            errors++; $display("FAIL iwait_plain: got %b required 1010",
                               {act.stallF, act.stallD, act.flushD, act.flushE});
        end
        tick();
        clearInputs();
        hz.longE = 1; hz.wrE = 1; hz.edst = 5'd14;
        tick();
        clearInputs();
        reset = 1;
        tick();
        act = sampleDut(); checks++;
        if ({act.pending, act.longCnt, act.stallCycles} !== '0) begin
            errors++; $display("FAIL reset_mid_div: got %h required 0", act);
        end
        reset = 0;
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 600; c++) begin
            clearInputs();
            reset      = ($urandom_range(0, 199) == 0);
            hz.d_wait  = ($urandom_range(0, 99) < 12);
            hz.i_wait  = ($urandom_range(0, 99) < 15);
            hz.dbranch = ($urandom_range(0, 99) < 25);
            for (int i = 0; i < NSRC; i++) begin
                hz.ra_d[i*AW +: AW] = AW'($urandom_range(0, 7));
                hz.ra_e[i*AW +: AW] = AW'($urandom_range(0, 7));
            end
            hz.wr_d   = $urandom_range(0, 1);
            hz.dst_d  = AW'($urandom_range(0, 7));
            hz.long_d = ($urandom_range(0, 99) < 30);
            hz.edst   = AW'($urandom_range(0, 7));
            hz.mdst   = AW'($urandom_range(0, 7));
            hz.wdst   = AW'($urandom_range(0, 7));
            hz.wrE    = $urandom_range(0, 1);
            hz.wrM    = $urandom_range(0, 1);
            hz.wrW    = $urandom_range(0, 1);
            hz.memrdE = $urandom_range(0, 1);
            hz.memrdM = $urandom_range(0, 1);
            n = mInflight.size();
            if (n > 0 && $urandom_range(0, 99) < 35) begin
                hz.long_done = 1;
                hz.long_dst  = mInflight[$urandom_range(0, n - 1)];
            end else begin
                hz.long_dst  = AW'($urandom_range(0, 7));
            end
            hz.longE = ($urandom_range(0, 99) < 35) && (n < MAX_LONG || hz.long_done);
            #1;
            act = sampleDut(); exp = modelOut(); checks++;
            if (act !== exp) begin
                errors++; $display("FAIL random c%0d: got %h required %h", c, act, exp);
            end
            tick();
        end
        reset = 0;
        clearInputs();
    endtask

    initial begin
        reset = 1;
        clearInputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_long_dep();
        test_cap();
        test_dwait_issue();
        test_fwd_long();
        test_branch_iwait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
